// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl
//   Memory/IO slave directly behind the CPU core. It maps a byte RAM at
//   RAM_BASE and an IO page at IO_BASE. The IO page holds an output byte
//   FIFO (DATA) and its status register (STATUS). A loader port can fill
//   the RAM while the CPU is held in reset.
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       asynchronous, active-low reset
//   adress_bus  CPU address
//   date_bus    CPU data bus; this block drives it only during a read data phase
//   r, w        CPU read / write strobes
//   ld_en       loader write enable
//   ld_addr     loader RAM index
//   ld_data     loader data
//   out_data    FIFO head byte
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head byte
//   bus_err     one-cycle pulse per bad access (unmapped, illegal write,
//               dropped write, or both strobes high)
//
// IO map
//   IO_BASE+0  DATA    write pushes a byte; read peeks at the head (00 if empty)
//   IO_BASE+1  STATUS  {3'b0, count (sat. 7), empty, full}, read-only
module bus_mem_ctrl #(
   parameter int unsigned ADDR_BITS  = 10,
   parameter logic [15:0] RAM_BASE   = 16'h2000,
   parameter logic [15:0] IO_BASE    = 16'hFF00,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          adress_bus,
   inout  wire  [7:0]           date_bus,
   input  logic                 r,
   input  logic                 w,
   input  logic                 ld_en,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [7:0]           ld_data,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 bus_err
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   // 17 bits so that a RAM window ending at 16'hFFFF still compares correctly
   localparam logic [16:0] RAM_END     = {1'b0, RAM_BASE} + (17'd1 << ADDR_BITS);
   localparam logic [15:0] STATUS_ADDR = IO_BASE + 16'd1;

   logic [7:0]           ram [2**ADDR_BITS];
   logic [7:0]           fifo_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 oe_q;
   logic [7:0]           rdata_q;

   logic                 ram_hit;
   logic                 io_data_hit;
   logic                 io_stat_hit;
   logic                 unmapped;
   logic [ADDR_BITS-1:0] ram_idx;
   logic                 rd_acc;
   logic                 wr_acc;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 ram_wr;
   logic                 err_d;
   logic [2:0]           cnt_sat;
   logic [31:0]          cnt_w;
   logic [7:0]           rd_val;

   // ---------------- decode ----------------
   assign ram_hit     = ({1'b0, adress_bus} >= {1'b0, RAM_BASE}) &&
                        ({1'b0, adress_bus} < RAM_END);
   assign ram_idx     = ADDR_BITS'(adress_bus - RAM_BASE);
   assign io_data_hit = ~ram_hit && (adress_bus == IO_BASE);
   assign io_stat_hit = ~ram_hit && (adress_bus == STATUS_ADDR);
   assign unmapped    = ~ram_hit && ~io_data_hit && ~io_stat_hit;

   // Both strobes high is not an access at all.
   assign rd_acc = r & ~w;
   assign wr_acc = w & ~r;

   // ---------------- FIFO control ----------------
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign out_valid = ~empty;
   assign out_data  = fifo_mem[rd_ptr];
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // accepted when the consumer is draining.
   assign push      = wr_acc & io_data_hit & (~full | pop);

   // The loader owns the RAM write port when both want it.
   assign ram_wr = wr_acc & ram_hit & ~ld_en;

   always_comb begin
      cnt_w   = 32'(count);
      cnt_sat = (cnt_w > 32'd7) ? 3'd7 : cnt_w[2:0];
   end

   always_comb begin
      rd_val = 8'hFF;
      if (ram_hit) begin
         rd_val = ram[ram_idx];
      end else if (io_data_hit) begin
         rd_val = empty ? 8'h00 : fifo_mem[rd_ptr];
      end else if (io_stat_hit) begin
         rd_val = {3'b000, cnt_sat, empty, full};
      end
   end

   assign err_d = (r & w) |
                  (rd_acc & unmapped) |
                  (wr_acc & (unmapped | io_stat_hit | (ram_hit & ld_en) |
                             (io_data_hit & full & ~pop)));

   // ---------------- bus drive ----------------
   assign date_bus = oe_q ? rdata_q : 8'bz;

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oe_q    <= 1'b0;
         rdata_q <= 8'h00;
         bus_err <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         bus_err <= err_d;
         if (rd_acc) begin
            oe_q    <= 1'b1;
            rdata_q <= rd_val;
         end else begin
            oe_q    <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Storage arrays carry no reset; their contents survive reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else if (ram_wr) begin
         ram[ram_idx] <= date_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= date_bus;
      end
   end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
`timescale 1ns/1ps
module tb_bus_mem_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] adress_bus;
   wire  [7:0]  date_bus;
   logic        r;
   logic        w;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [7:0]  ld_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        bus_err;

   logic        drv_en;
   logic [7:0]  drv_data;

   assign date_bus = drv_en ? drv_data : 8'bz;

   bus_mem_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .adress_bus (adress_bus),
      .date_bus   (date_bus),
      .r          (r),
      .w          (w),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bus_err    (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [15:0] addr;
      logic        r;
      logic        w;
      logic [7:0]  wdata;
      logic        le;
      logic [9:0]  la;
      logic [7:0]  ld;
      logic        ordy;
      logic        e_oe;
      logic [7:0]  e_bus;
      logic        e_err;
      logic        e_valid;
      logic [7:0]  e_head;
   } vec_t;

   // ---------------- reference model ----------------
   // RAM as a plain byte array, FIFO as a queue of bytes.
   logic [7:0] mram [1024];
   logic [7:0] mq [$];
   logic       m_oe;
   logic [7:0] m_rd;
   logic       m_err;

   task automatic model_step(input vec_t v);
      logic [7:0] rv;
      logic       hit_ram;
      logic       hit_io;
      logic       is_full;
      logic       do_pop;
      int         idx;
      int         n;
      n       = mq.size();
      hit_ram = (v.addr >= 16'h2000) && (v.addr < 16'h2400);
      hit_io  = (v.addr == 16'hFF00) || (v.addr == 16'hFF01);
      idx     = int'(v.addr) - 'h2000;
      is_full = (n == 4);
      do_pop  = (n != 0) && v.ordy;
      if (hit_ram)                rv = mram[idx];
      else if (v.addr == 16'hFF00) rv = (n != 0) ? mq[0] : 8'h00;
      else if (v.addr == 16'hFF01) rv = {3'b000, 3'(n), (n == 0), is_full};
      else                        rv = 8'hFF;
      m_err = 1'b0;
      if (v.r && v.w)  m_err = 1'b1;
      else if (v.r)    m_err = !hit_ram && !hit_io;
      else if (v.w)    m_err = (!hit_ram && !hit_io) || (v.addr == 16'hFF01) ||
                               (hit_ram && v.le) ||
                               ((v.addr == 16'hFF00) && is_full && !do_pop);
      m_oe = v.r && !v.w;
      if (m_oe) m_rd = rv;
      if (v.w && !v.r && hit_ram && !v.le) mram[idx] = v.wdata;
      if (v.le) mram[v.la] = v.ld;
      if (do_pop) void'(mq.pop_front());
      if (v.w && !v.r && (v.addr == 16'hFF00) && (!is_full || do_pop)) mq.push_back(v.wdata);
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
      end
   endtask

   // An undriven bus reads as z (4-state) or 00 (2-state); anything else means
   // the DUT is still driving.
   task automatic chk_float(input string nm);
      n_cmp++;
      if (!((date_bus === 8'hzz) || (date_bus === 8'h00))) begin
         n_bad++;
         $display("FAIL %s: got bus %02h, expected released (zz)", nm, date_bus);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] a, input logic rr, input logic ww,
                               input logic [7:0] d, input logic e_oe, input logic [7:0] e_bus,
                               input logic e_err, input logic e_valid, input logic [7:0] e_head);
      vec_t v;
      v.addr = a;   v.r = rr;   v.w = ww;   v.wdata = d;
      v.le = 1'b0;  v.la = 10'd0; v.ld = 8'h00; v.ordy = 1'b0;
      v.e_oe = e_oe; v.e_bus = e_bus; v.e_err = e_err;
      v.e_valid = e_valid; v.e_head = e_head;
      return v;
   endfunction

   function automatic vec_t with_ld(input vec_t vi, input logic [9:0] la, input logic [7:0] ld);
      vec_t v;
      v = vi;
      v.le = 1'b1; v.la = la; v.ld = ld;
      return v;
   endfunction

   function automatic vec_t idle(input logic e_valid, input logic [7:0] e_head);
      return mk(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, e_valid, e_head);
   endfunction

   task automatic do_cycle(input vec_t v);
      adress_bus = v.addr;
      r          = v.r;
      w          = v.w;
      ld_en      = v.le;
      ld_addr    = v.la;
      ld_data    = v.ld;
      out_ready  = v.ordy;
      drv_data   = v.wdata;
      drv_en     = v.w && !v.r;
      model_step(v);
      @(posedge clk);
      #1;
      drv_en = 1'b0;
      r      = 1'b0;
      w      = 1'b0;
      ld_en  = 1'b0;
      #1;
   endtask

   task automatic chk_vec(input vec_t v, input string tag);
      chk({tag, "_err"}, 8'(bus_err), 8'(v.e_err));
      chk({tag, "_valid"}, 8'(out_valid), 8'(v.e_valid));
      if (v.e_valid) chk({tag, "_head"}, out_data, v.e_head);
      if (v.e_oe) chk({tag, "_bus"}, date_bus, v.e_bus);
      else        chk_float({tag, "_float"});
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_err"}, 8'(bus_err), 8'(m_err));
      chk({tag, "_valid"}, 8'(out_valid), 8'(mq.size() != 0));
      if (mq.size() != 0) chk({tag, "_head"}, out_data, mq[0]);
      if (m_oe) chk({tag, "_bus"}, date_bus, m_rd);
      else      chk_float({tag, "_float"});
   endtask

   vec_t       tbl [$];
   vec_t       v;
   logic [7:0] hs [$];
   logic [15:0] addr_pool [16];
   logic [9:0]  la_pool [10];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_oe = 1'b0; m_err = 1'b0; m_rd = 8'h00;
      reset = 1'b0;
      adress_bus = 16'h0000; r = 1'b0; w = 1'b0;
      ld_en = 1'b0; ld_addr = 10'd0; ld_data = 8'h00; out_ready = 1'b0;
      drv_en = 1'b0; drv_data = 8'h00;
      addr_pool = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005,
                    16'h2006, 16'h2007, 16'h2010, 16'h23FF, 16'hFF00, 16'hFF00,
                    16'hFF01, 16'h2400, 16'h1FFF, 16'hFF02};
      la_pool   = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7,
                    10'd16, 10'd1023};

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_err", 8'(bus_err), 8'h00);
      chk("rst_valid", 8'(out_valid), 8'h00);
      chk_float("rst_bus");
      #2 reset = 1'b1;

      // ---------------- RAM preload through the loader ----------------
      for (int i = 0; i < 10; i++) begin
         v = with_ld(idle(1'b0, 8'h00), la_pool[i],
                     (i == 9) ? 8'h7E : ((i == 8) ? 8'h00 : 8'(8'h10 + i)));
         do_cycle(v);
      end

      // ---------------- directed vector table ----------------
      tbl.push_back(with_ld(idle(1'b0, 8'h00), 10'd0, 8'hA5));
      tbl.push_back(mk(16'h2000, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00));
      tbl.push_back(idle(1'b0, 8'h00));
      tbl.push_back(mk(16'h2010, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      tbl.push_back(mk(16'h2010, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00));
      tbl.push_back(mk(16'h23FF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0, 8'h00));
      tbl.push_back(mk(16'h2400, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00));
      tbl.push_back(mk(16'h1FFF, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00));
      tbl.push_back(idle(1'b0, 8'h00));
      tbl.push_back(mk(16'hFF01, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      tbl.push_back(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00));
      tbl.push_back(idle(1'b0, 8'h00));
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(16'hFF00, 1'b0, 1'b1, 8'(8'h11 * k), 1'b0, 8'h00,
                          (k == 5), 1'b1, 8'h11));
      tbl.push_back(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11));
      tbl.push_back(mk(16'hFF00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11));
      tbl.push_back(idle(1'b1, 8'h11));
      tbl.push_back(mk(16'hFF00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11));
      tbl.push_back(mk(16'h2000, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11));
      tbl.push_back(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11));
      tbl.push_back(mk(16'h2000, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h11));
      tbl.push_back(idle(1'b1, 8'h11));
      tbl.push_back(with_ld(mk(16'h2001, 1'b0, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11),
                            10'd1, 8'h66));
      tbl.push_back(mk(16'h2001, 1'b1, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b1, 8'h11));
      tbl.push_back(with_ld(mk(16'h2002, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b1, 8'h11),
                            10'd2, 8'h77));
      tbl.push_back(mk(16'h2002, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h11));

      foreach (tbl[i]) begin
         do_cycle(tbl[i]);
         chk_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // ---------------- full FIFO, push and pop together ----------------
      do_cycle(idle(1'b1, 8'h11));
      hs = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 10; i++) begin
         v = mk(16'hFF00, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
         v.ordy = 1'b1;
         do_cycle(v);
         void'(hs.pop_front());
         hs.push_back(8'(8'h80 + i));
         chk($sformatf("pp%0d_err", i), 8'(bus_err), 8'h00);
         chk($sformatf("pp%0d_head", i), out_data, hs[0]);
      end
      do_cycle(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      chk("pp_status", date_bus, 8'h11);
      for (int i = 0; i < 4; i++) begin
         v = idle(1'b0, 8'h00);
         v.ordy = 1'b1;
         do_cycle(v);
         void'(hs.pop_front());
         chk($sformatf("drain%0d_valid", i), 8'(out_valid), 8'(hs.size() != 0));
         if (hs.size() != 0) chk($sformatf("drain%0d_head", i), out_data, hs[0]);
      end
      do_cycle(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      chk("drain_status", date_bus, 8'h02);

      // ---------------- reset mid-read ----------------
      do_cycle(idle(1'b0, 8'h00));
      do_cycle(mk(16'hFF00, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A));
      chk("mr_valid_pre", 8'(out_valid), 8'h01);
      do_cycle(mk(16'h2000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A));
      chk("mr_bus_pre", date_bus, 8'hA5);
      adress_bus = 16'h2000;
      r = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk_float("mr_float");
      chk("mr_valid", 8'(out_valid), 8'h00);
      chk("mr_err", 8'(bus_err), 8'h00);
      mq.delete();
      m_oe = 1'b0;
      m_err = 1'b0;
      r = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      do_cycle(idle(1'b0, 8'h00));
      chk("mr_post_valid", 8'(out_valid), 8'h00);
      do_cycle(mk(16'hFF01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      chk("mr_status", date_bus, 8'h02);
      do_cycle(mk(16'h2000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      chk("mr_ram_kept", date_bus, 8'hA5);

      // ---------------- randomized traffic vs. model ----------------
      begin
         logic prev_rd;
         int   op;
         prev_rd = 1'b1;
         for (int i = 0; i < 500; i++) begin
            op = int'($urandom_range(0, 9));
            if (op >= 6 && op <= 8 && prev_rd) op = 0;
            v = mk(addr_pool[$urandom_range(0, 15)],
                   (op >= 3 && op <= 5) || (op == 9),
                   (op >= 6),
                   8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            v.ordy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
               v.le = 1'b1;
               v.la = la_pool[$urandom_range(0, 9)];
               v.ld = 8'($urandom);
            end
            prev_rd = v.r && !v.w;
            do_cycle(v);
            chk_model($sformatf("rnd%0d", i));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_mem_ctrl.md
Name: bus_mem_ctrl

Overview:
Memory/IO slave that sits directly downstream of the CPU core and consumes its adress_bus, date_bus, r and w strobes. It serves program/data RAM and a memory-mapped output port. The output port is a 4-entry byte FIFO drained through a valid/ready handshake, with a status register. It also has a loader port that fills RAM before or while the CPU is held in reset.

Parameters:
ADDR_BITS, 10, RAM address width; RAM depth = 2**ADDR_BITS bytes
RAM_BASE, 16'h2000, first CPU address mapped to RAM (the CPU reset PC)
IO_BASE, 16'hFF00, base of the IO page
FIFO_DEPTH, 4, output FIFO entries (power of two, at least 2)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
adress_bus  in  16  CPU address
date_bus  inout  8  CPU data bus; driven only during a read data phase, otherwise 8'bz
r  in  1  CPU read strobe
w  in  1  CPU write strobe
ld_en  in  1  loader write enable
ld_addr  in  ADDR_BITS  loader RAM address
ld_data  in  8  loader data
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head byte
bus_err  out  1  one-cycle pulse on an access to an unmapped address or on r and w both high

Behaviour:
Address decode:
- RAM hit: RAM_BASE <= addr < RAM_BASE + 2**ADDR_BITS; RAM index = addr - RAM_BASE, truncated to ADDR_BITS.
- IO_BASE+0 (DATA): write pushes date_bus into the FIFO; read returns the FIFO head without popping it (8'h00 if empty).
- IO_BASE+1 (STATUS), read-only: bit0 = full, bit1 = empty, bits[4:2] = count (saturates at 7), bits[7:5] = 0. A write is ignored and raises bus_err.
- Any other address is unmapped: read returns 8'hFF and raises bus_err; write is dropped and raises bus_err.

Read timing:
- On a posedge with r=1, w=0: rdata_q <= decoded value and oe_q <= 1.
- While oe_q=1, date_bus = rdata_q; oe_q clears on the first posedge with r=0.
- Back-to-back reads (r held high, address changing) re-latch every posedge.
- Latency is one clock.

Write timing:
- On a posedge with w=1, r=0: capture date_bus and address in that cycle.
- RAM writes take effect for a read of the same address on the next posedge.

Strobe conflicts:
- r=1 and w=1: no access; oe_q forced to 0; bus_err pulses.

Loader:
- On a posedge with ld_en=1: RAM[ld_addr] <= ld_data.
- A same-cycle CPU RAM write is dropped (loader wins) and bus_err pulses.
- A CPU read in the same cycle returns the old RAM contents.

FIFO:
- Circular buffer; ptr width = log2(FIFO_DEPTH); count width = log2(FIFO_DEPTH)+1.
- Push when a CPU DATA write occurs and not full. Push while full: byte dropped, bus_err pulses.
- Pop when out_valid && out_ready.
- Simultaneous push and pop: allowed even when full; count unchanged; pointers both advance and wrap modulo FIFO_DEPTH.
- out_data = mem[rd_ptr] (combinational from registered state); out_valid = (count != 0).
- Pointers wrap silently.

Reset (async, reset=0):
- oe_q=0 (date_bus=z), rdata_q=0, FIFO pointers and count = 0, out_valid=0, bus_err=0.
- RAM contents are not reset.
- An access in flight when reset asserts is abandoned.
- The first posedge after reset release is a normal cycle.

bus_err is registered, high for exactly one cycle per offending access.

Test Plan:
- Loader writes 8'hA5 to ld_addr 0; CPU reads 16'h2000 with r=1 -> date_bus=8'hA5 one cycle later; bus_err=0.
- CPU writes 8'h3C to 16'h2010, then reads it on the next cycle -> 8'h3C; the top RAM byte 16'h23FF is readable; a read of 16'h2400 -> 8'hFF and a bus_err pulse.
- Five writes to 16'hFF00 with out_ready=0 -> the first 4 are stored; STATUS reads 8'h11 (full, count=4); the fifth write raises bus_err; out_data = first byte.
- FIFO full, then push and pop in the same cycle -> count stays 4; out_data advances; pointer wrap is verified over 10 such cycles with no byte loss or reordering.
- r=1 and w=1 together -> date_bus stays z, no RAM/FIFO change, bus_err=1 for one cycle.
- reset pulled low mid-read with oe_q=1 -> date_bus goes z immediately; out_valid=0; STATUS reads 8'h02 after release.
